// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver: parity encodings and
// receiver FSM states.
package uart_rx_param_pkg;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_EVEN = 1;
  localparam int UART_PAR_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop,
    StDone,
    StBrk
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wr_data_i,
  output logic [Width-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CntW'(Depth));
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised line, centre sampling, optional
// parity, 1-2 stop bits, sticky error flags and a receive FIFO.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DIV        = 16,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx,
  input  logic                            rd_en,
  input  logic                            err_clr,
  output logic [DATA_W-1:0]               rd_data,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            rx_busy,
  output logic                            rx_end,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overrun
);

  if (DIV < 4 || DATA_W < 5 || DATA_W > 8 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 ||
      STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_rx_param: illegal parameter combination");
  end

  localparam int DivW = $clog2(DIV);
  localparam int IdxW = $clog2(DATA_W);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(DIV / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  rx_state_e         state_q;
  logic              sync1_q, sync2_q, rx_prev_q, rx_s;
  logic [DivW-1:0]   div_cnt_q;
  logic [IdxW-1:0]   bit_idx_q;
  logic              stop_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              bad_par_q, bad_frame_q, busy_q;
  logic              par_err_q, frame_err_q, overrun_q;
  logic              done, local_ok, push;

  assign rx_s     = sync2_q;
  assign done     = (state_q == StDone);
  assign local_ok = !bad_par_q && !bad_frame_q;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the frame.
  assign push     = done && local_ok && (!full || rd_en);

  assign rx_end     = push;
  assign rx_busy    = busy_q;
  assign parity_err = par_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      div_cnt_q   <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      bad_par_q   <= 1'b0;
      bad_frame_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= rx_s;
      div_cnt_q <= div_cnt_q + DivW'(1);
      unique case (state_q)
        StIdle: begin
          if (rx_prev_q && !rx_s) begin
            state_q   <= StStart;
            div_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        StStart: begin
          if (div_cnt_q == DivHalf) begin
            div_cnt_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q     <= StData;
              bit_idx_q   <= '0;
              stop_idx_q  <= 1'b0;
              bad_par_q   <= 1'b0;
              bad_frame_q <= 1'b0;
            end
          end
        end
        StData: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            shift_q   <= {rx_s, shift_q[DATA_W-1:1]};
            bit_idx_q <= bit_idx_q + IdxW'(1);
            if (bit_idx_q == IdxLast) begin
              state_q <= (PARITY != UART_PAR_NONE) ? StPar : StStop;
            end
          end
        end
        StPar: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            bad_par_q <= ((^shift_q) ^ rx_s) != (PARITY == UART_PAR_ODD);
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_q  <= '0;
            stop_idx_q <= 1'b1;
            if (!rx_s) begin
              bad_frame_q <= 1'b1;
            end
            if (stop_idx_q == 1'(STOP_BITS - 1)) begin
              state_q <= StDone;
            end
          end
        end
        StDone, StBrk: begin
          // A line still low after the frame is a break: hold busy until it rises.
          if (rx_s) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StBrk;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      par_err_q   <= (done && bad_par_q) || (par_err_q && !err_clr);
      frame_err_q <= (done && bad_frame_q) || (frame_err_q && !err_clr);
      overrun_q   <= (done && local_ok && full && !rd_en) || (overrun_q && !err_clr);
    end
  end

  uart_rx_fifo #(
    .Width(DATA_W),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_i    (reset),
    .push_i   (push),
    .pop_i    (rd_en),
    .wr_data_i(shift_q),
    .rd_data_o(rd_data),
    .empty_o  (empty),
    .full_o   (full),
    .count_o  (count)
  );

endmodule
